// File: rtl/window_spill_fill_ctrl_if.sv
// Bus bundle between the register-window manager and its CU, register file and memory port.
// master = window manager side, slave = environment side.
interface window_spill_fill_ctrl_if;
    logic        save;
    logic        restore;
    logic [31:0] spill_base;
    logic [31:0] fill_base;
    logic [1:0]  cwp;
    logic [3:0]  wim;
    logic        busy;
    logic        done;
    logic        req_err;
    logic [1:0]  rf_window;
    logic [4:0]  rf_rnum;
    logic        rf_en;
    logic        rf_rw;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  save, restore, spill_base, fill_base, rf_rdata, mem_rdata, mem_ack,
        output cwp, wim, busy, done, req_err, rf_window, rf_rnum, rf_en, rf_rw, rf_wdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output save, restore, spill_base, fill_base, rf_rdata, mem_rdata, mem_ack,
        input  cwp, wim, busy, done, req_err, rf_window, rf_rnum, rf_en, rf_rw, rf_wdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/window_spill_fill_ctrl.sv
// Register-window manager: owns CWP/WIM, executes SAVE/RESTORE, spills/fills windows on traps.
// Define AUTO_SPILL_FILL_EN to compile the hardware spill/fill engine; otherwise traps raise req_err.
module window_spill_fill_ctrl #(
    parameter int unsigned     NWIN      = 4,
    parameter logic [NWIN-1:0] RESET_WIM = 4'b0010
) (
    input logic                      Clk,
    input logic                      Clr,
    window_spill_fill_ctrl_if.master bus
);
    localparam int unsigned WW = $clog2(NWIN);

`ifdef AUTO_SPILL_FILL_EN
    localparam int unsigned AW = 32;
    localparam int unsigned KW = 4;
    localparam int unsigned RW = 5;

    typedef enum logic [2:0] {IDLE, SPILL_RD, SPILL_MEM, FILL_MEM, FILL_WR, COMMIT} state_t;
`else
    typedef enum logic [2:0] {IDLE} state_t;
`endif

    state_t          state_q, state_d;
    logic [WW-1:0]   cwp_q, cwp_d;
    logic [NWIN-1:0] wim_q, wim_d;
    logic            done_q, done_d;
    logic            req_err_q, req_err_d;
    logic [WW-1:0]   save_tgt, rest_tgt;

    assign save_tgt = cwp_q - WW'(1);
    assign rest_tgt = cwp_q + WW'(1);

`ifdef AUTO_SPILL_FILL_EN
    logic [KW-1:0] k_q, k_d;
    logic [WW-1:0] win_q, win_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] mem_wdata_q, mem_wdata_d;
    logic [AW-1:0] rf_wdata_q, rf_wdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [WW-1:0] rf_window_q, rf_window_d;
    logic [RW-1:0] rf_rnum_q, rf_rnum_d;
    logic          busy_q, busy_d;
    logic          rf_en_q, rf_en_d;
    logic          rf_rw_q, rf_rw_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
`endif

    // State and output registers
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q     <= IDLE;
            cwp_q       <= '0;
            wim_q       <= RESET_WIM;
            done_q      <= 1'b0;
            req_err_q   <= 1'b0;
`ifdef AUTO_SPILL_FILL_EN
            k_q         <= '0;
            win_q       <= '0;
            base_q      <= '0;
            mem_wdata_q <= '0;
            rf_wdata_q  <= '0;
            mem_addr_q  <= '0;
            rf_window_q <= '0;
            rf_rnum_q   <= '0;
            busy_q      <= 1'b0;
            rf_en_q     <= 1'b0;
            rf_rw_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cwp_q       <= cwp_d;
            wim_q       <= wim_d;
            done_q      <= done_d;
            req_err_q   <= req_err_d;
`ifdef AUTO_SPILL_FILL_EN
            k_q         <= k_d;
            win_q       <= win_d;
            base_q      <= base_d;
            mem_wdata_q <= mem_wdata_d;
            rf_wdata_q  <= rf_wdata_d;
            mem_addr_q  <= mem_addr_d;
            rf_window_q <= rf_window_d;
            rf_rnum_q   <= rf_rnum_d;
            busy_q      <= busy_d;
            rf_en_q     <= rf_en_d;
            rf_rw_q     <= rf_rw_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
`endif
        end
    end

    // Next state; outputs are decoded from the next state so they appear registered
    always_comb begin
        state_d   = state_q;
        cwp_d     = cwp_q;
        wim_d     = wim_q;
        done_d    = 1'b0;
        req_err_d = 1'b0;
`ifdef AUTO_SPILL_FILL_EN
        k_d         = k_q;
        win_d       = win_q;
        base_d      = base_q;
        mem_wdata_d = mem_wdata_q;
        rf_wdata_d  = rf_wdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.save && bus.restore) begin
                    req_err_d = 1'b1;
                end else if (bus.save) begin
                    if (!wim_q[save_tgt]) begin
                        cwp_d  = save_tgt;
                        done_d = 1'b1;
                    end else begin
`ifdef AUTO_SPILL_FILL_EN
                        state_d = SPILL_RD;
                        k_d     = '0;
                        win_d   = cwp_q - WW'(2);
                        base_d  = bus.spill_base;
`else
                        req_err_d = 1'b1;
`endif
                    end
                end else if (bus.restore) begin
                    if (!wim_q[rest_tgt]) begin
                        cwp_d  = rest_tgt;
                        done_d = 1'b1;
                    end else begin
`ifdef AUTO_SPILL_FILL_EN
                        state_d = FILL_MEM;
                        k_d     = '0;
                        win_d   = rest_tgt;
                        base_d  = bus.fill_base;
`else
                        req_err_d = 1'b1;
`endif
                    end
                end
            end
`ifdef AUTO_SPILL_FILL_EN
            SPILL_RD: begin
                mem_wdata_d = bus.rf_rdata;
                state_d     = SPILL_MEM;
            end
            SPILL_MEM: begin
                if (bus.mem_ack) begin
                    if (k_q == '1) begin
                        state_d = COMMIT;
                        cwp_d   = save_tgt;
                        wim_d   = NWIN'(1) << win_q;
                        done_d  = 1'b1;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = SPILL_RD;
                    end
                end
            end
            FILL_MEM: begin
                if (bus.mem_ack) begin
                    rf_wdata_d = bus.mem_rdata;
                    state_d    = FILL_WR;
                end
            end
            FILL_WR: begin
                if (k_q == '1) begin
                    state_d = COMMIT;
                    cwp_d   = win_q;
                    wim_d   = NWIN'(1) << (win_q + WW'(1));
                    done_d  = 1'b1;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = FILL_MEM;
                end
            end
            COMMIT: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

`ifdef AUTO_SPILL_FILL_EN
        busy_d      = (state_d != IDLE);
        rf_en_d     = (state_d == SPILL_RD) || (state_d == FILL_WR);
        rf_rw_d     = (state_d == FILL_WR);
        rf_window_d = rf_en_d ? win_d : cwp_d;
        rf_rnum_d   = rf_en_d ? {1'b1, k_d} : '0;
        mem_req_d   = (state_d == SPILL_MEM) || (state_d == FILL_MEM);
        mem_we_d    = (state_d == SPILL_MEM);
        mem_addr_d  = mem_req_d ? base_d + {{(AW-KW-2){1'b0}}, k_d, 2'b00} : '0;
`endif
    end

    assign bus.cwp     = cwp_q;
    assign bus.wim     = wim_q;
    assign bus.done    = done_q;
    assign bus.req_err = req_err_q;

`ifdef AUTO_SPILL_FILL_EN
    assign bus.busy      = busy_q;
    assign bus.rf_window = rf_window_q;
    assign bus.rf_rnum   = rf_rnum_q;
    assign bus.rf_en     = rf_en_q;
    assign bus.rf_rw     = rf_rw_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
`else
    // Trap-only build: register file follows CWP, memory port stays quiet
    assign bus.busy      = 1'b0;
    assign bus.rf_window = cwp_q;
    assign bus.rf_rnum   = '0;
    assign bus.rf_en     = 1'b0;
    assign bus.rf_rw     = 1'b0;
    assign bus.rf_wdata  = '0;
    assign bus.mem_req   = 1'b0;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_addr  = '0;
    assign bus.mem_wdata = '0;

    logic unused_inputs;
    assign unused_inputs = ^{bus.spill_base, bus.fill_base, bus.rf_rdata, bus.mem_rdata, bus.mem_ack};
`endif
endmodule

// File: tb/tb_window_spill_fill_ctrl.sv
// Scoreboard bench for window_spill_fill_ctrl: models the register file and a handshaking memory.
// Expectations follow AUTO_SPILL_FILL_EN the same way the design does.
module tb_window_spill_fill_ctrl;
    logic Clk = 1'b0;
    logic Clr;
    always #5 Clk = ~Clk;

    window_spill_fill_ctrl_if bus ();

    window_spill_fill_ctrl #(.NWIN(4), .RESET_WIM(4'b0010)) dut (
        .Clk(Clk),
        .Clr(Clr),
        .bus(bus.master)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_txn_t;

    typedef struct packed {
        logic [1:0]  win;
        logic [4:0]  rnum;
        logic [31:0] data;
    } rf_txn_t;

    mem_txn_t    mem_q[$];
    rf_txn_t     rf_q[$];
    logic [31:0] rf_mem [4][32];
    int          total = 0;
    int          bad = 0;
    int          ack_lat = 0;
    logic [31:0] fill_base_tb = 32'h0;
    logic [31:0] fill_val0 = 32'h0;
    logic [1:0]  m_cwp;
    logic [3:0]  m_wim;

    assign bus.rf_rdata = rf_mem[bus.rf_window][bus.rf_rnum];

    always @(posedge Clk) begin
        if (bus.rf_en && bus.rf_rw) rf_mem[bus.rf_window][bus.rf_rnum] <= bus.rf_wdata;
    end

    // Memory responder and scoreboard checker for memory and register-file writes
    initial begin
        int wait_cnt;
        mem_txn_t me;
        rf_txn_t re;
        wait_cnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge Clk);
            if (bus.mem_req === 1'b1 && bus.mem_ack !== 1'b1) begin
                if (wait_cnt >= ack_lat) begin
                    if (Clr !== 1'b1) begin
                        total++;
                        if (mem_q.size() == 0) begin
                            bad++;
                            $display("FAIL mem_unexpected: got we=%0b addr=%h, want no request", bus.mem_we, bus.mem_addr);
                        end else begin
                            me = mem_q.pop_front();
                            if (bus.mem_we !== me.we || bus.mem_addr !== me.addr ||
                                (me.we && bus.mem_wdata !== me.data)) begin
                                bad++;
                                $display("FAIL mem_txn: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                                         bus.mem_we, bus.mem_addr, bus.mem_wdata, me.we, me.addr, me.data);
                            end
                        end
                    end
                    bus.mem_rdata = fill_val0 + ((bus.mem_addr - fill_base_tb) >> 2);
                    bus.mem_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                bus.mem_rdata = 32'hDEAD_BEEF;
                wait_cnt = 0;
            end
            if (bus.rf_en === 1'b1 && bus.rf_rw === 1'b1) begin
                total++;
                if (rf_q.size() == 0) begin
                    bad++;
                    $display("FAIL rf_unexpected: got win=%0d r=%0d data=%h, want no write", bus.rf_window, bus.rf_rnum, bus.rf_wdata);
                end else begin
                    re = rf_q.pop_front();
                    if (bus.rf_window !== re.win || bus.rf_rnum !== re.rnum || bus.rf_wdata !== re.data) begin
                        bad++;
                        $display("FAIL rf_write: got win=%0d r=%0d data=%h, want win=%0d r=%0d data=%h",
                                 bus.rf_window, bus.rf_rnum, bus.rf_wdata, re.win, re.rnum, re.data);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic s, input logic r);
        @(negedge Clk);
        bus.save = s;
        bus.restore = r;
        @(negedge Clk);
        bus.save = 1'b0;
        bus.restore = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
        Clr = 1'b0;
        m_cwp = 2'd0;
        m_wim = 4'b0010;
    endtask

    // Counts busy cycles and done pulses from the current negedge; pokes a request at poke_at
    task automatic run_until_idle(input int poke_at, output int cyc, output int dn);
        cyc = 0;
        dn = 0;
        for (int i = 0; i < 400 && bus.busy === 1'b1; i++) begin
            if (bus.done === 1'b1) dn++;
            cyc++;
            bus.save = (i == poke_at);
            @(negedge Clk);
        end
        bus.save = 1'b0;
    endtask

    task automatic test_reset();
        Clr = 1'b1;
        bus.save = 1'b0;
        bus.restore = 1'b0;
        bus.spill_base = 32'h0;
        bus.fill_base = 32'h0;
        repeat (3) @(negedge Clk);
        total++;
        if (bus.cwp !== 2'd0 || bus.wim !== 4'b0010) begin
            bad++;
            $display("FAIL reset_cwp_wim: got cwp=%0d wim=%b, want cwp=0 wim=0010", bus.cwp, bus.wim);
        end
        total++;
        if ({bus.busy, bus.done, bus.req_err, bus.rf_en, bus.rf_rw, bus.mem_req, bus.mem_we} !== 7'b0 ||
            bus.mem_addr !== 32'h0 || bus.rf_window !== 2'd0 || bus.rf_rnum !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b rf_en=%b rf_rw=%b req=%b we=%b addr=%h, want all 0",
                     bus.busy, bus.done, bus.req_err, bus.rf_en, bus.rf_rw, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        @(negedge Clk);
        Clr = 1'b0;
        m_cwp = 2'd0;
        m_wim = 4'b0010;
    endtask

    task automatic test_save_no_trap();
        logic [1:0] want [2];
        want[0] = 2'd3;
        want[1] = 2'd2;
        for (int n = 0; n < 2; n++) begin
            pulse(1'b1, 1'b0);
            total++;
            if (bus.cwp !== want[n] || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.wim !== 4'b0010) begin
                bad++;
                $display("FAIL save_nt%0d: got cwp=%0d done=%b busy=%b wim=%b, want cwp=%0d done=1 busy=0 wim=0010",
                         n, bus.cwp, bus.done, bus.busy, bus.wim, want[n]);
            end
            @(negedge Clk);
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL save_nt_pulse%0d: got done=%b busy=%b, want 0 0", n, bus.done, bus.busy);
            end
        end
        m_cwp = 2'd2;
    endtask

    task automatic test_overflow_spill();
        int cyc;
        int dn;
        bus.spill_base = 32'h0000_1000;
        ack_lat = 0;
`ifdef AUTO_SPILL_FILL_EN
        for (int k = 0; k < 16; k++)
            mem_q.push_back('{1'b1, 32'h0000_1000 + 32'(4 * k), rf_mem[0][16 + k]});
        pulse(1'b1, 1'b0);
        bus.spill_base = 32'hFFFF_0000;
        run_until_idle(3, cyc, dn);
        total++;
        if (cyc !== 33 || dn !== 1) begin
            bad++;
            $display("FAIL spill_busy: got busy_cycles=%0d done_pulses=%0d, want 33 1", cyc, dn);
        end
        m_cwp = 2'd1;
        m_wim = 4'b0001;
        total++;
        if (bus.cwp !== m_cwp || bus.wim !== m_wim || mem_q.size() != 0) begin
            bad++;
            $display("FAIL spill_commit: got cwp=%0d wim=%b pending=%0d, want cwp=1 wim=0001 pending=0",
                     bus.cwp, bus.wim, mem_q.size());
        end
`else
        pulse(1'b1, 1'b0);
        total++;
        if (bus.req_err !== 1'b1 || bus.cwp !== 2'd2 || bus.wim !== 4'b0010 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL overflow_trap: got err=%b cwp=%0d wim=%b busy=%b done=%b, want err=1 cwp=2 wim=0010 busy=0 done=0",
                     bus.req_err, bus.cwp, bus.wim, bus.busy, bus.done);
        end
        repeat (3) @(negedge Clk);
        total++;
        if (bus.req_err !== 1'b0 || bus.cwp !== 2'd2) begin
            bad++;
            $display("FAIL overflow_trap_after: got err=%b cwp=%0d, want err=0 cwp=2", bus.req_err, bus.cwp);
        end
`endif
    endtask

    task automatic test_both_err();
        pulse(1'b1, 1'b1);
        total++;
        if (bus.req_err !== 1'b1 || bus.cwp !== m_cwp || bus.wim !== m_wim || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL both_err: got err=%b cwp=%0d wim=%b done=%b busy=%b, want err=1 cwp=%0d wim=%b done=0 busy=0",
                     bus.req_err, bus.cwp, bus.wim, bus.done, bus.busy, m_cwp, m_wim);
        end
        @(negedge Clk);
        total++;
        if (bus.req_err !== 1'b0 || bus.cwp !== m_cwp) begin
            bad++;
            $display("FAIL both_err_pulse: got err=%b cwp=%0d, want err=0 cwp=%0d", bus.req_err, bus.cwp, m_cwp);
        end
    endtask

    task automatic test_underflow_fill();
`ifdef AUTO_SPILL_FILL_EN
        int cyc;
        int dn;
        logic [31:0] fb [2];
        logic [31:0] fv [2];
        int lat [2];
        int want_cyc;
        fb[0] = 32'hFFFF_FFF0;
        fv[0] = 32'h50;
        lat[0] = 2;
        fb[1] = 32'h0000_2000;
        fv[1] = 32'hA0;
        lat[1] = 0;
        do_clr();
        for (int n = 0; n < 2; n++) begin
            fill_base_tb = fb[n];
            fill_val0 = fv[n];
            ack_lat = lat[n];
            bus.fill_base = fb[n];
            for (int k = 0; k < 16; k++) begin
                mem_q.push_back('{1'b0, fb[n] + 32'(4 * k), 32'h0});
                rf_q.push_back('{2'(n + 1), 5'(16 + k), fv[n] + 32'(k)});
            end
            pulse(1'b0, 1'b1);
            bus.fill_base = 32'h0BAD_0000;
            run_until_idle(-1, cyc, dn);
            want_cyc = 33 + 16 * lat[n];
            total++;
            if (cyc !== want_cyc || dn !== 1) begin
                bad++;
                $display("FAIL fill%0d_busy: got busy_cycles=%0d done_pulses=%0d, want %0d 1", n, cyc, dn, want_cyc);
            end
            m_cwp = 2'(n + 1);
            m_wim = 4'b0100 << n;
            total++;
            if (bus.cwp !== m_cwp || bus.wim !== m_wim || mem_q.size() != 0 || rf_q.size() != 0) begin
                bad++;
                $display("FAIL fill%0d_commit: got cwp=%0d wim=%b pending=%0d/%0d, want cwp=%0d wim=%b pending=0/0",
                         n, bus.cwp, bus.wim, mem_q.size(), rf_q.size(), m_cwp, m_wim);
            end
        end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (rf_mem[2][16 + k] !== 32'hA0 + 32'(k)) begin
                bad++;
                $display("FAIL fill_rf_w2_r%0d: got %h, want %h", 16 + k, rf_mem[2][16 + k], 32'hA0 + 32'(k));
            end
        end
`else
        logic [1:0] want [2];
        want[0] = 2'd3;
        want[1] = 2'd0;
        for (int n = 0; n < 2; n++) begin
            pulse(1'b0, 1'b1);
            total++;
            if (bus.cwp !== want[n] || bus.done !== 1'b1 || bus.req_err !== 1'b0) begin
                bad++;
                $display("FAIL restore_nt%0d: got cwp=%0d done=%b err=%b, want cwp=%0d done=1 err=0",
                         n, bus.cwp, bus.done, bus.req_err, want[n]);
            end
        end
        pulse(1'b0, 1'b1);
        total++;
        if (bus.req_err !== 1'b1 || bus.cwp !== 2'd0 || bus.wim !== 4'b0010 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL underflow_trap: got err=%b cwp=%0d wim=%b busy=%b done=%b, want err=1 cwp=0 wim=0010 busy=0 done=0",
                     bus.req_err, bus.cwp, bus.wim, bus.busy, bus.done);
        end
`endif
    endtask

    task automatic test_clr_mid_spill();
        logic hit;
        do_clr();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        bus.spill_base = 32'h0000_4000;
        ack_lat = 0;
`ifdef AUTO_SPILL_FILL_EN
        for (int k = 0; k < 5; k++)
            mem_q.push_back('{1'b1, 32'h0000_4000 + 32'(4 * k), rf_mem[0][16 + k]});
`endif
        pulse(1'b1, 1'b0);
        hit = 1'b0;
`ifdef AUTO_SPILL_FILL_EN
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge Clk);
            #1;
            if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h0000_4014) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL clr_reach_word5: got no request at 00004014, want one");
        end
`else
        @(posedge Clk);
        #1;
`endif
        Clr = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Clr = 1'b0;
        total++;
        if (bus.cwp !== 2'd0 || bus.wim !== 4'b0010 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.rf_en !== 1'b0 || mem_q.size() != 0) begin
            bad++;
            $display("FAIL clr_mid: got cwp=%0d wim=%b req=%b busy=%b done=%b rf_en=%b pending=%0d, want 0 0010 0 0 0 0 0",
                     bus.cwp, bus.wim, bus.mem_req, bus.busy, bus.done, bus.rf_en, mem_q.size());
        end
        pulse(1'b1, 1'b0);
        total++;
        if (bus.cwp !== 2'd3 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL clr_then_save: got cwp=%0d done=%b busy=%b, want cwp=3 done=1 busy=0", bus.cwp, bus.done, bus.busy);
        end
    endtask

    initial begin
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 32; r++)
                rf_mem[w][r] = 32'hC000_0000 + 32'(w * 256 + r);
        test_reset();
        test_save_no_trap();
        test_overflow_spill();
        test_both_err();
        test_underflow_fill();
        test_clr_mid_spill();
        repeat (3) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
